gnn_0_example_load: RTL and testbench

- Load engine: the DRAM-to-buffer counterpart of the save path.
- Decodes one load instruction and requests N lines from the AXI read master.
- Accepts the read master's AXI-stream beats and writes them, one line per beat, into the on-chip buffer from a start address.
- Sits between the ctrl module (ap_start/ap_done), the AXI read master (rd_ctrl_* and s_axis_*), and the buffer write port.

---
 rtl/gnn_0_example_load.sv | 171 +++++++++++++++++
 tb/tb_gnn_0_example_load.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnn_0_example_load.sv
// gnn_0_example_load: load engine, DRAM -> on-chip buffer.
// Decodes one load instruction, asks the AXI read master for N lines, and
// writes the returned stream beats into the buffer, one line per beat,
// starting at the instruction's buffer address.
//
// Ports
//   aclk, areset                 clock, asynchronous active-high reset
//   ap_start / ap_done           start pulse in, one-cycle completion pulse out
//   ctrl_addr_offset             DRAM base address
//   ctrl_instruction             [95:80] N, [79:48] DRAM offset, [47:32] buffer start
//   rd_ctrl_*                    read-master request (start pulse, address, size, done)
//   s_axis_*                     read data stream from the read master
//   load_write_buffer_*          buffer write port (valid/ready, line address, data)
module gnn_0_example_load #(
    parameter int unsigned LOAD_INST_LENGTH   = 96,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
    parameter int unsigned C_BUF_ADDR_WIDTH   = 11,
    parameter int unsigned C_FIFO_DEPTH       = 4
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          ap_start,
    output logic                          ap_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    input  logic [LOAD_INST_LENGTH-1:0]   ctrl_instruction,
    output logic                          rd_ctrl_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] rd_ctrl_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]  rd_ctrl_xfer_size_in_bytes,
    input  logic                          rd_ctrl_done,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] s_axis_tdata,
    output logic                          load_write_buffer_valid,
    output logic [C_BUF_ADDR_WIDTH-1:0]   load_write_buffer_addr,
    output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_data,
    input  logic                          load_write_buffer_ready
);

    localparam int unsigned PTR_W          = $clog2(C_FIFO_DEPTH);
    localparam int unsigned CNT_W          = $clog2(C_FIFO_DEPTH) + 1;
    localparam int unsigned BYTES_PER_BEAT = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, ISSUE, STREAM, FLUSH, DONE} state_t;

    state_t                          state_q;
    logic [15:0]                     n_q;
    logic [15:0]                     rx_cnt_q;
    logic [15:0]                     wr_cnt_q;
    logic                            rd_done_seen_q;
    logic [C_BUF_ADDR_WIDTH-1:0]     cur_addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   fifo_q [C_FIFO_DEPTH];
    logic [PTR_W-1:0]                head_q;
    logic [PTR_W-1:0]                tail_q;
    logic [CNT_W-1:0]                fifo_cnt_q;
    logic                            ap_done_q;
    logic                            rd_ctrl_start_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   rd_addr_q;
    logic [C_XFER_SIZE_WIDTH-1:0]    rd_size_q;

    logic fifo_full;
    logic fifo_empty;
    logic tready;
    logic push;
    logic pop;

    // Reserved instruction bits and unused high bits of the buffer field.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{ctrl_instruction[31:0],
                                ctrl_instruction[47:32+C_BUF_ADDR_WIDTH]};

    always_comb begin
        fifo_full  = (fifo_cnt_q == CNT_W'(C_FIFO_DEPTH));
        fifo_empty = (fifo_cnt_q == '0);
        tready     = 1'b0;
        if (state_q == STREAM) begin
            tready = !fifo_full && (rx_cnt_q < n_q);
        end else if (state_q == FLUSH) begin
            // Surplus beats from the read master are drained and dropped.
            tready = 1'b1;
        end
        push = (state_q == STREAM) && s_axis_tvalid && tready;
        pop  = !fifo_empty && load_write_buffer_ready;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q         <= IDLE;
            n_q             <= '0;
            rx_cnt_q        <= '0;
            wr_cnt_q        <= '0;
            rd_done_seen_q  <= 1'b0;
            cur_addr_q      <= '0;
            head_q          <= '0;
            tail_q          <= '0;
            fifo_cnt_q      <= '0;
            ap_done_q       <= 1'b0;
            rd_ctrl_start_q <= 1'b0;
            rd_addr_q       <= '0;
            rd_size_q       <= '0;
            for (int unsigned i = 0; i < C_FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            ap_done_q       <= 1'b0;
            rd_ctrl_start_q <= 1'b0;

            if (push) begin
                fifo_q[tail_q] <= s_axis_tdata;
                tail_q         <= tail_q + PTR_W'(1);
                rx_cnt_q       <= rx_cnt_q + 16'd1;
            end
            if (pop) begin
                head_q     <= head_q + PTR_W'(1);
                cur_addr_q <= cur_addr_q + C_BUF_ADDR_WIDTH'(1);
                wr_cnt_q   <= wr_cnt_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase

            if (state_q != IDLE && rd_ctrl_done) begin
                rd_done_seen_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (ap_start) begin
                        n_q        <= ctrl_instruction[95:80];
                        cur_addr_q <= ctrl_instruction[32 +: C_BUF_ADDR_WIDTH];
                        rd_addr_q  <= ctrl_addr_offset
                                      + C_M_AXI_ADDR_WIDTH'(ctrl_instruction[79:48]);
                        rd_size_q  <= C_XFER_SIZE_WIDTH'(ctrl_instruction[95:80])
                                      * C_XFER_SIZE_WIDTH'(BYTES_PER_BEAT);
                        if (ctrl_instruction[95:80] == 16'd0) begin
                            state_q <= DONE;
                        end else begin
                            state_q         <= ISSUE;
                            rd_ctrl_start_q <= 1'b1;
                        end
                    end
                end
                ISSUE:  state_q <= STREAM;
                STREAM: if (rx_cnt_q == n_q) state_q <= FLUSH;
                FLUSH:  if (wr_cnt_q == n_q && rd_done_seen_q) state_q <= DONE;
                DONE: begin
                    // Clearing here overrides the sticky set above.
                    ap_done_q      <= 1'b1;
                    rx_cnt_q       <= '0;
                    wr_cnt_q       <= '0;
                    rd_done_seen_q <= 1'b0;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ap_done                    = ap_done_q;
    assign rd_ctrl_start              = rd_ctrl_start_q;
    assign rd_ctrl_addr_offset        = rd_addr_q;
    assign rd_ctrl_xfer_size_in_bytes = rd_size_q;
    assign s_axis_tready              = tready;
    assign load_write_buffer_valid    = !fifo_empty;
    assign load_write_buffer_addr     = cur_addr_q;
    assign load_write_buffer_data     = fifo_q[head_q];

endmodule

// File: tb/tb_gnn_0_example_load.sv
// Self-checking bench for gnn_0_example_load: random line data, random
// stream/buffer back-pressure, expected writes derived from N, buffer start
// and the beat list.
module tb_gnn_0_example_load;

    localparam int AW = 64;
    localparam int DW = 512;
    localparam int XW = 32;
    localparam int BW = 11;
    localparam int IL = 96;

    logic          aclk = 1'b0;
    logic          areset;
    logic          ap_start;
    logic          ap_done;
    logic [AW-1:0] ctrl_addr_offset;
    logic [IL-1:0] ctrl_instruction;
    logic          rd_ctrl_start;
    logic [AW-1:0] rd_ctrl_addr_offset;
    logic [XW-1:0] rd_ctrl_xfer_size_in_bytes;
    logic          rd_ctrl_done;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          load_write_buffer_valid;
    logic [BW-1:0] load_write_buffer_addr;
    logic [DW-1:0] load_write_buffer_data;
    logic          load_write_buffer_ready;

    gnn_0_example_load #(
        .LOAD_INST_LENGTH(IL), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW),
        .C_XFER_SIZE_WIDTH(XW), .C_BUF_ADDR_WIDTH(BW), .C_FIFO_DEPTH(4)
    ) dut (
        .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_done(ap_done),
        .ctrl_addr_offset(ctrl_addr_offset), .ctrl_instruction(ctrl_instruction),
        .rd_ctrl_start(rd_ctrl_start), .rd_ctrl_addr_offset(rd_ctrl_addr_offset),
        .rd_ctrl_xfer_size_in_bytes(rd_ctrl_xfer_size_in_bytes),
        .rd_ctrl_done(rd_ctrl_done), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .load_write_buffer_valid(load_write_buffer_valid),
        .load_write_buffer_addr(load_write_buffer_addr),
        .load_write_buffer_data(load_write_buffer_data),
        .load_write_buffer_ready(load_write_buffer_ready)
    );

    always #5 aclk = ~aclk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model expectations and observations of the latest run.
    logic [BW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    logic [BW-1:0] obs_addr[$];
    logic [DW-1:0] obs_data[$];
    int            start_cnt, start_cyc, done_cnt, done_cyc, rd_done_cyc, last_wr_cyc;
    int            max_occ, overflow_err, unstable_err, stall_tready_low;
    logic [AW-1:0] start_addr;
    logic [XW-1:0] start_size;
    logic [3:0]    snap_ctrl;
    logic [BW-1:0] snap_addr;
    logic [DW-1:0] snap_data;
    logic [AW-1:0] snap_rdaddr;
    logic [XW-1:0] snap_size;

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic idle_inputs();
        ap_start = 0; rd_ctrl_done = 0; s_axis_tvalid = 0; s_axis_tdata = '0;
        load_write_buffer_ready = 0;
    endtask

    // Drives one load instruction cycle by cycle. Outputs are sampled at the
    // negedge; the handshakes decided there complete at the following posedge.
    task automatic run_load(input logic [15:0] n, input logic [31:0] off,
                            input logic [AW-1:0] base, input logic [BW-1:0] bstart,
                            input int extra, input int done_mode,
                            input int stall_at, input int stall_len,
                            input int rand_ready, input int rand_valid, input int rst_at);
        logic [DW-1:0] beats[$];
        int   acc, occ, pushed, cyc, stall_left, post_done;
        bit   stall_used, rd_pulsed;
        logic pv, pr;
        logic [BW-1:0] pa;
        logic [DW-1:0] pd;
        exp_addr.delete(); exp_data.delete(); obs_addr.delete(); obs_data.delete();
        start_cnt = 0; start_cyc = -1; done_cnt = 0; done_cyc = -1; rd_done_cyc = -1;
        last_wr_cyc = -1; max_occ = 0; overflow_err = 0; unstable_err = 0;
        stall_tready_low = 0; start_addr = '0; start_size = '0;
        for (int i = 0; i < int'(n) + extra; i++) begin
            beats.push_back(rand_line());
            if (i < int'(n)) begin
                exp_addr.push_back(BW'(int'(bstart) + i));
                exp_data.push_back(beats[i]);
            end
        end
        ctrl_addr_offset = base;
        ctrl_instruction = {n, off, 16'(bstart), 32'($urandom())};
        acc = 0; cyc = 0; stall_left = 0; post_done = -1; stall_used = 0; rd_pulsed = 0;
        pv = 0; pr = 0; pa = '0; pd = '0;
        @(negedge aclk);
        while (cyc < 600) begin
            if (rd_ctrl_start) begin
                start_cnt++; start_cyc = cyc;
                start_addr = rd_ctrl_addr_offset; start_size = rd_ctrl_xfer_size_in_bytes;
            end
            if (ap_done) begin
                done_cnt++; done_cyc = cyc;
                if (post_done < 0) post_done = 3;
            end
            if (pv && !pr && (!load_write_buffer_valid || load_write_buffer_addr !== pa
                              || load_write_buffer_data !== pd))
                unstable_err++;
            pushed = (acc < int'(n)) ? acc : int'(n);
            occ = pushed - obs_addr.size();
            if (occ > max_occ) max_occ = occ;
            if (occ >= 4 && s_axis_tready && acc < int'(n)) overflow_err++;

            if (rst_at >= 0 && obs_addr.size() == rst_at) begin
                areset = 1; idle_inputs();
                #1;
                snap_ctrl   = {ap_done, rd_ctrl_start, s_axis_tready, load_write_buffer_valid};
                snap_addr   = load_write_buffer_addr;
                snap_data   = load_write_buffer_data;
                snap_rdaddr = rd_ctrl_addr_offset;
                snap_size   = rd_ctrl_xfer_size_in_bytes;
                @(negedge aclk);
                areset = 0;
                repeat (4) begin
                    @(negedge aclk);
                    if (ap_done) done_cnt++;
                end
                break;
            end

            ap_start = (cyc == 0);
            if (stall_at >= 0 && !stall_used && obs_addr.size() == stall_at) begin
                stall_left = stall_len; stall_used = 1;
            end
            if (stall_left > 0) begin
                load_write_buffer_ready = 0; stall_left--;
                if (!s_axis_tready && acc < int'(n) && occ == 4) stall_tready_low++;
            end else begin
                load_write_buffer_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            s_axis_tvalid = (acc < beats.size()) && (rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1);
            s_axis_tdata  = (acc < beats.size()) ? beats[acc] : '0;
            rd_ctrl_done = 0;
            if (done_mode == 1 && rd_ctrl_start) begin
                rd_ctrl_done = 1; rd_done_cyc = cyc;
            end else if (done_mode == 0 && !rd_pulsed && acc == int'(n) && cyc >= 2) begin
                rd_ctrl_done = 1; rd_pulsed = 1; rd_done_cyc = cyc;
            end

            if (load_write_buffer_valid && load_write_buffer_ready) begin
                obs_addr.push_back(load_write_buffer_addr);
                obs_data.push_back(load_write_buffer_data);
                last_wr_cyc = cyc;
            end
            if (s_axis_tvalid && s_axis_tready) acc++;
            pv = load_write_buffer_valid; pr = load_write_buffer_ready;
            pa = load_write_buffer_addr;  pd = load_write_buffer_data;

            if (post_done > 0) post_done--;
            if (post_done == 0) break;
            @(negedge aclk);
            cyc++;
        end
        idle_inputs();
        repeat (2) @(negedge aclk);
    endtask

    task automatic test_reset();
        areset = 1; idle_inputs();
        ctrl_addr_offset = '0; ctrl_instruction = '0;
        repeat (3) @(posedge aclk);
        #1;
        n_total++; if ({ap_done, rd_ctrl_start, s_axis_tready, load_write_buffer_valid} !== 4'b0)
            $display("FAIL reset_ctrl got=%b exp=0000", {ap_done, rd_ctrl_start, s_axis_tready, load_write_buffer_valid});
        else n_pass++;
        n_total++; if (load_write_buffer_addr !== '0 || load_write_buffer_data !== '0)
            $display("FAIL reset_buf got addr=%h exp=0", load_write_buffer_addr);
        else n_pass++;
        n_total++; if (rd_ctrl_addr_offset !== '0 || rd_ctrl_xfer_size_in_bytes !== '0)
            $display("FAIL reset_rdctrl got=%h/%h exp=0/0", rd_ctrl_addr_offset, rd_ctrl_xfer_size_in_bytes);
        else n_pass++;
        @(negedge aclk);
        areset = 0;
        repeat (2) @(negedge aclk);
    endtask

    task automatic test_basic();
        run_load(16'd4, 32'h100, 64'h1000_0000, 11'h010, 0, 0, -1, 0, 0, 0, -1);
        n_total++; if (start_cnt !== 1 || start_cyc !== 1)
            $display("FAIL basic_start got cnt=%0d cyc=%0d exp cnt=1 cyc=1", start_cnt, start_cyc);
        else n_pass++;
        n_total++; if (start_addr !== 64'h1000_0100 || start_size !== 32'd256)
            $display("FAIL basic_req got=%h/%0d exp=10000100/256", start_addr, start_size);
        else n_pass++;
        n_total++; if (obs_addr.size() !== 4)
            $display("FAIL basic_nwr got=%0d exp=4", obs_addr.size());
        else n_pass++;
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            n_total++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL basic_wr%0d got addr=%h exp addr=%h (or data differs)", i, obs_addr[i], exp_addr[i]);
            else n_pass++;
        end
        n_total++; if (done_cnt !== 1 || done_cyc <= rd_done_cyc)
            $display("FAIL basic_done got cnt=%0d cyc=%0d exp cnt=1 after %0d", done_cnt, done_cyc, rd_done_cyc);
        else n_pass++;
    endtask

    task automatic test_stall();
        run_load(16'd8, 32'h40, 64'h2000, 11'h100, 0, 0, 2, 10, 0, 0, -1);
        n_total++; if (obs_addr.size() !== 8)
            $display("FAIL stall_nwr got=%0d exp=8", obs_addr.size());
        else n_pass++;
        for (int i = 0; i < obs_addr.size() && i < 8; i++) begin
            n_total++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL stall_wr%0d got addr=%h exp addr=%h (or data differs)", i, obs_addr[i], exp_addr[i]);
            else n_pass++;
        end
        n_total++; if (unstable_err !== 0)
            $display("FAIL stall_stable got=%0d exp=0", unstable_err);
        else n_pass++;
        n_total++; if (max_occ !== 4 || overflow_err !== 0 || stall_tready_low == 0)
            $display("FAIL stall_backpressure got occ=%0d ovf=%0d low=%0d exp occ=4 ovf=0 low>0",
                     max_occ, overflow_err, stall_tready_low);
        else n_pass++;
        n_total++; if (done_cnt !== 1)
            $display("FAIL stall_done got=%0d exp=1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_zero();
        run_load(16'd0, 32'h80, 64'h3000, 11'h020, 0, 0, -1, 0, 0, 0, -1);
        n_total++; if (done_cnt !== 1 || done_cyc !== 2)
            $display("FAIL zero_done got cnt=%0d cyc=%0d exp cnt=1 cyc=2", done_cnt, done_cyc);
        else n_pass++;
        n_total++; if (start_cnt !== 0 || obs_addr.size() !== 0)
            $display("FAIL zero_quiet got starts=%0d writes=%0d exp 0/0", start_cnt, obs_addr.size());
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [BW-1:0] want[4];
        want[0] = 11'h7FE; want[1] = 11'h7FF; want[2] = 11'h000; want[3] = 11'h001;
        run_load(16'd4, 32'h0, 64'h0, 11'h7FE, 0, 0, -1, 0, 1, 1, -1);
        n_total++; if (obs_addr.size() !== 4)
            $display("FAIL wrap_nwr got=%0d exp=4", obs_addr.size());
        else n_pass++;
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            n_total++; if (obs_addr[i] !== want[i] || obs_data[i] !== exp_data[i])
                $display("FAIL wrap_wr%0d got addr=%h exp addr=%h (or data differs)", i, obs_addr[i], want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_issue_done();
        run_load(16'd2, 32'h200, 64'h4000, 11'h050, 1, 1, -1, 0, 1, 0, -1);
        n_total++; if (obs_addr.size() !== 2)
            $display("FAIL early_done_nwr got=%0d exp=2", obs_addr.size());
        else n_pass++;
        for (int i = 0; i < obs_addr.size() && i < 2; i++) begin
            n_total++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                $display("FAIL early_done_wr%0d got addr=%h exp addr=%h (or data differs)", i, obs_addr[i], exp_addr[i]);
            else n_pass++;
        end
        n_total++; if (done_cnt !== 1 || done_cyc <= last_wr_cyc)
            $display("FAIL early_done_wait got cnt=%0d cyc=%0d exp cnt=1 after %0d", done_cnt, done_cyc, last_wr_cyc);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        run_load(16'd6, 32'h300, 64'h5000, 11'h060, 0, 0, -1, 0, 0, 0, 2);
        n_total++; if (snap_ctrl !== 4'b0 || snap_addr !== '0 || snap_data !== '0)
            $display("FAIL midrst_outputs got ctrl=%b addr=%h exp ctrl=0000 addr=0", snap_ctrl, snap_addr);
        else n_pass++;
        n_total++; if (snap_rdaddr !== '0 || snap_size !== '0)
            $display("FAIL midrst_rdctrl got=%h/%h exp=0/0", snap_rdaddr, snap_size);
        else n_pass++;
        n_total++; if (done_cnt !== 0 || obs_addr.size() !== 2)
            $display("FAIL midrst_nodone got done=%0d writes=%0d exp 0/2", done_cnt, obs_addr.size());
        else n_pass++;
        run_load(16'd1, 32'h40, 64'h6000, 11'h070, 0, 0, -1, 0, 0, 0, -1);
        n_total++; if (obs_addr.size() !== 1 || done_cnt !== 1 || start_cnt !== 1)
            $display("FAIL midrst_after got writes=%0d done=%0d starts=%0d exp 1/1/1",
                     obs_addr.size(), done_cnt, start_cnt);
        else n_pass++;
        n_total++; if (obs_addr.size() > 0 && (obs_addr[0] !== 11'h070 || obs_data[0] !== exp_data[0]))
            $display("FAIL midrst_after_wr got addr=%h exp addr=070 (or data differs)", obs_addr[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            logic [15:0] n;
            logic [31:0] off;
            logic [AW-1:0] base;
            logic [BW-1:0] bs;
            logic [AW-1:0] want_addr;
            n    = 16'($urandom_range(1, 12));
            off  = $urandom();
            base = {32'($urandom()), 32'($urandom())};
            bs   = BW'($urandom());
            want_addr = base + {32'd0, off};
            run_load(n, off, base, bs, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                     -1, 0, 1, 1, -1);
            n_total++; if (start_addr !== want_addr || start_size !== XW'(n) * 64)
                $display("FAIL rand%0d_req got=%h/%0d exp=%h/%0d", t, start_addr, start_size, want_addr, XW'(n) * 64);
            else n_pass++;
            n_total++; if (obs_addr.size() !== int'(n) || done_cnt !== 1)
                $display("FAIL rand%0d_count got writes=%0d done=%0d exp %0d/1", t, obs_addr.size(), done_cnt, n);
            else n_pass++;
            for (int i = 0; i < obs_addr.size() && i < int'(n); i++) begin
                n_total++; if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i])
                    $display("FAIL rand%0d_wr%0d got addr=%h exp addr=%h (or data differs)", t, i, obs_addr[i], exp_addr[i]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_wrap();
        test_issue_done();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
